seg_pattern_reader: RTL and testbench
=====================================

Name: seg_pattern_reader

Overview:
- Receive-side counterpart of the digit-to-segment encoder: samples a 7-bit active-low seven-segment pattern bus and decodes it back to a 5-bit digit index (0-9, A-H, U, blank).
- Used for board loopback checks and for reading segment outputs of the checkers display into the processor.
- Synchronises and debounces the input, reports each newly stable pattern once, and holds it in a valid/ready output register.

Parameters:
- STABLE_CYCLES, 4, consecutive equal synchronised samples required before a pattern is accepted; legal range 1..2^CNT_W-1.
- CNT_W, 8, width of the stability counter.

Ports:
- clock  input  1  single clock.
- reset  input  1  synchronous, active-high reset.
- seg_in  input  7  segment bus, asynchronous; bit6=g ... bit0=a; active-low.
- enable  input  1  when 0, the stability counter is held at 0 and no reports are made.
- out_ready  input  1  consumer accepts the report when high together with out_valid.
- out_valid  output  1  report pending.
- out_index  output  5  decoded index 0..19; 31 when the pattern is invalid.
- out_error  output  1  pending report is an unrecognised pattern.
- out_overrun  output  1  sticky: a report was dropped because the output register was full.

Behaviour:
- Code table (index:pattern g..a):
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001
  - 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0011000
  - 10(A):0001000, 11(B):0000011, 12(C):1000110, 13(D):0100001, 14(E):0000110
  - 15(F):0001110, 16(G):1000010, 17(H):0001001, 18(U):1000001, 19(blank):1111111
  - Any other pattern gives index 31 and error=1.
- Synchroniser:
  - s1 <= seg_in; s2 <= s1; prev <= s2.
  - All three reset to 1111111.
- Stability counter cnt:
  - If enable=0 or s2!=prev, cnt <= 0.
  - Otherwise cnt <= min(cnt+1, STABLE_CYCLES).
  - Resets to 0.
- Accept event occurs on an edge where enable=1, s2==prev, cnt==STABLE_CYCLES-1, and s2!=last_acc. On that edge:
  - last_acc <= s2.
  - A report is generated.
- last_acc:
  - Resets to 1111111, so a blank bus after reset is never reported.
  - Unchanged while enable=0.
- Glitch handling: a glitch that returns to the previously accepted pattern produces no report.
- Latency: with seg_in = P set up before edge k and held, out_valid rises after edge k+2+STABLE_CYCLES (edge k+6 at default).
- Output register (out_valid, out_index, out_error):
  - Load on report when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle; out_valid stays 1 in the latter case.
  - Clear out_valid on out_valid&&out_ready with no report.
  - Report while out_valid=1 and out_ready=0: the report is dropped, out_overrun <= 1 (held until reset), and the register is unchanged.
- out_index/out_error hold stable while out_valid=1 and out_ready=0.
- Reset values: out_valid=0, out_index=19, out_error=0, out_overrun=0.
- Reset asserted mid-debounce or mid-handshake discards everything.
- No combinational path from seg_in or out_ready to any output.

Decomposition:
- Shared include file seg_codes.vh holds:
  - The 20 pattern constants and their index constants.
  - IDX_INVALID=31 and SEG_BLANK=7'b1111111.
  - The encoder also uses this file, so both ends share one table.
- Sub-module seg_pattern_decoder: combinational, pattern[6:0] -> index[4:0], error. Verified standalone against all 128 inputs.

Test Plan:
- Reset, hold seg_in=1111111 for 50 cycles -> out_valid stays 0, out_index=19.
- seg_in=0100100 held, out_ready=1 -> out_valid=1 for one cycle exactly 6 edges after the change, out_index=2, out_error=0.
- Sweep all 20 table codes, each held 10 cycles with a ready consumer -> 20 reports in order, indices 0..19.
  - Note: blank (19) is reported only because the previous pattern differed.
- seg_in=0000000 held 3 cycles, then 1111001 held 10 -> single report index=1, no report for 8; pulse 8 for 1 cycle back to 1 -> no report.
- seg_in=0101010 held -> out_index=31, out_error=1.
- out_ready=0, present 3 then 4 -> out_index stays 3, out_overrun=1 after the 4 is accepted; raise out_ready -> report 3 consumed, out_valid=0; reset clears out_overrun.

Source files
------------

// File: rtl/seg_pattern_reader_pkg.sv
// Shared seven-segment code table (active-low, bit6=g .. bit0=a) and index names.
// The digit-to-segment encoder imports the same constants so both ends agree.
package seg_pattern_reader_pkg;

  typedef enum logic [4:0] {
    IDX_0 = 5'd0, IDX_1, IDX_2, IDX_3, IDX_4, IDX_5, IDX_6, IDX_7, IDX_8, IDX_9,
    IDX_A, IDX_B, IDX_C, IDX_D, IDX_E, IDX_F, IDX_G, IDX_H, IDX_U, IDX_BLANK,
    IDX_INVALID = 5'd31
  } seg_index_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_G     = 7'b1000010;
  localparam logic [6:0] SEG_H     = 7'b0001001;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg_pattern_decoder.sv
// Combinational reverse lookup: active-low segment pattern to digit index.
// Anything outside the code table maps to IDX_INVALID with error raised.
module seg_pattern_decoder
  import seg_pattern_reader_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [4:0] index_o,
  output logic       error_o
);

  always_comb begin
    index_o = IDX_INVALID;
    case (pattern_i)
      SEG_0:     index_o = IDX_0;
      SEG_1:     index_o = IDX_1;
      SEG_2:     index_o = IDX_2;
      SEG_3:     index_o = IDX_3;
      SEG_4:     index_o = IDX_4;
      SEG_5:     index_o = IDX_5;
      SEG_6:     index_o = IDX_6;
      SEG_7:     index_o = IDX_7;
      SEG_8:     index_o = IDX_8;
      SEG_9:     index_o = IDX_9;
      SEG_A:     index_o = IDX_A;
      SEG_B:     index_o = IDX_B;
      SEG_C:     index_o = IDX_C;
      SEG_D:     index_o = IDX_D;
      SEG_E:     index_o = IDX_E;
      SEG_F:     index_o = IDX_F;
      SEG_G:     index_o = IDX_G;
      SEG_H:     index_o = IDX_H;
      SEG_U:     index_o = IDX_U;
      SEG_BLANK: index_o = IDX_BLANK;
      default:   index_o = IDX_INVALID;
    endcase
    error_o = (index_o == IDX_INVALID);
  end

endmodule

// File: rtl/seg_pattern_reader.sv
// Synchronises and debounces a segment bus, decodes each newly stable pattern
// once, and presents it through a valid/ready register with a sticky overrun flag.
module seg_pattern_reader
  import seg_pattern_reader_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] seg_in,
  input  logic       enable,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [4:0] out_index,
  output logic       out_error,
  output logic       out_overrun
);

  localparam logic [CNT_W-1:0] CntMax    = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CntAccept = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]       s1_q, s2_q, prev_q;
  logic [6:0]       lastAcc_q, lastAcc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             outValid_q, outValid_d;
  logic [4:0]       outIndex_q, outIndex_d;
  logic             outError_q, outError_d;
  logic             overrun_q, overrun_d;
  logic             stable, accept;
  logic [4:0]       decIndex;
  logic             decError;

  seg_pattern_decoder u_decoder (
    .pattern_i (s2_q),
    .index_o   (decIndex),
    .error_o   (decError)
  );

  // Accept fires once per stable run, and only when the pattern differs from
  // the last accepted one, so glitches back to it stay silent.
  always_comb begin
    stable    = enable && (s2_q == prev_q);
    accept    = stable && (cnt_q == CntAccept) && (s2_q != lastAcc_q);
    cnt_d     = '0;
    if (stable) begin
      cnt_d = (cnt_q >= CntMax) ? CntMax : cnt_q + 1'b1;
    end
    lastAcc_d = accept ? s2_q : lastAcc_q;

    outValid_d = outValid_q;
    outIndex_d = outIndex_q;
    outError_d = outError_q;
    overrun_d  = overrun_q;
    if (accept) begin
      if (!outValid_q || out_ready) begin
        outValid_d = 1'b1;
        outIndex_d = decIndex;
        outError_d = decError;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (outValid_q && out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q       <= SEG_BLANK;
      s2_q       <= SEG_BLANK;
      prev_q     <= SEG_BLANK;
      lastAcc_q  <= SEG_BLANK;
      cnt_q      <= '0;
      outValid_q <= 1'b0;
      outIndex_q <= IDX_BLANK;
      outError_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      s1_q       <= seg_in;
      s2_q       <= s1_q;
      prev_q     <= s2_q;
      lastAcc_q  <= lastAcc_d;
      cnt_q      <= cnt_d;
      outValid_q <= outValid_d;
      outIndex_q <= outIndex_d;
      outError_q <= outError_d;
      overrun_q  <= overrun_d;
    end
  end

  assign out_valid   = outValid_q;
  assign out_index   = outIndex_q;
  assign out_error   = outError_q;
  assign out_overrun = overrun_q;

endmodule

// File: tb/tb_seg_pattern_reader.sv
// Scoreboard bench for seg_pattern_reader: expected reports are queued as
// patterns are driven and compared when the consumer accepts each one.
module tb_seg_pattern_reader;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] seg_in = 7'b1111111;
  logic       enable = 1'b1;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [4:0] out_index;
  logic       out_error;
  logic       out_overrun;

  int vectors     = 0;
  int miscompares = 0;
  int reports     = 0;

  // Entries are {error, index}.
  logic [5:0] expQ[$];

  logic [6:0] codes [0:19] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000,
    7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110,
    7'b0001110, 7'b1000010, 7'b0001001, 7'b1000001, 7'b1111111
  };

  always #5 clock = ~clock;

  seg_pattern_reader #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .seg_in      (seg_in),
    .enable      (enable),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_index   (out_index),
    .out_error   (out_error),
    .out_overrun (out_overrun)
  );

  // Pops the scoreboard for any handshake the coming edge will complete,
  // then advances to 2 time units past that edge.
  task automatic stepCycle();
    logic [5:0] expv;
    if (!reset && out_valid && out_ready) begin
      vectors++;
      reports++;
      if (expQ.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL report: unexpected index=%0d error=%0b, expected no report", out_index, out_error);
      end else begin
        expv = expQ.pop_front();
        if ({out_error, out_index} !== expv) begin
          miscompares++;
          $display("[TB] FAIL report: index=%0d error=%0b, expected index=%0d error=%0b",
                   out_index, out_error, expv[4:0], expv[5]);
        end
      end
    end
    @(posedge clock);
    #2;
  endtask

  task automatic applyStimulus(input logic [6:0] pat, input int cycles);
    seg_in = pat;
    repeat (cycles) stepCycle();
  endtask

  task automatic checkDrained(input string name, input int startReports, input int wantReports);
    vectors++;
    if (expQ.size() != 0 || (reports - startReports) != wantReports) begin
      miscompares++;
      $display("[TB] FAIL %s: reports=%0d pending=%0d, expected reports=%0d pending=0",
               name, reports - startReports, expQ.size(), wantReports);
      expQ.delete();
    end
  endtask

  task automatic test_reset();
    logic sawValid;
    sawValid  = 1'b0;
    reset     = 1'b1;
    seg_in    = 7'b1111111;
    out_ready = 1'b1;
    repeat (3) stepCycle();
    reset = 1'b0;
    expQ.delete();
    repeat (50) begin
      stepCycle();
      if (out_valid) sawValid = 1'b1;
    end
    vectors++;
    if (sawValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_valid: out_valid seen=%0b, expected 0", sawValid);
    end
    vectors++;
    if (out_index !== 5'd19) begin
      miscompares++;
      $display("[TB] FAIL reset_index: out_index=%0d, expected 19", out_index);
    end
    vectors++;
    if (out_error !== 1'b0 || out_overrun !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: error=%0b overrun=%0b, expected 0 0", out_error, out_overrun);
    end
  endtask

  task automatic test_latency();
    int startReports;
    startReports = reports;
    out_ready = 1'b1;
    expQ.push_back({1'b0, 5'd2});
    seg_in = 7'b0100100;
    for (int e = 1; e <= 9; e++) begin
      stepCycle();
      vectors++;
      if (out_valid !== (e == 7)) begin
        miscompares++;
        $display("[TB] FAIL latency: after edge %0d out_valid=%0b, expected %0b", e, out_valid, (e == 7));
      end
    end
    checkDrained("latency_drain", startReports, 1);
  endtask

  task automatic test_sweep();
    int startReports;
    startReports = reports;
    for (int i = 0; i < 20; i++) begin
      expQ.push_back({1'b0, 5'(i)});
      applyStimulus(codes[i], 10);
    end
    checkDrained("sweep_drain", startReports, 20);
  endtask

  task automatic test_glitch();
    int startReports;
    startReports = reports;
    expQ.push_back({1'b0, 5'd1});
    applyStimulus(7'b0000000, 3);
    applyStimulus(7'b1111001, 10);
    applyStimulus(7'b0000000, 1);
    applyStimulus(7'b1111001, 10);
    checkDrained("glitch", startReports, 1);
  endtask

  task automatic test_invalid();
    int startReports;
    startReports = reports;
    expQ.push_back({1'b1, 5'd31});
    applyStimulus(7'b0101010, 10);
    checkDrained("invalid", startReports, 1);
  endtask

  task automatic test_enable();
    int startReports;
    startReports = reports;
    enable = 1'b0;
    applyStimulus(7'b0010010, 12);
    checkDrained("enable_off", startReports, 0);
    expQ.push_back({1'b0, 5'd5});
    enable = 1'b1;
    applyStimulus(7'b0010010, 8);
    checkDrained("enable_on", startReports, 1);
  endtask

  task automatic test_overrun();
    int startReports;
    startReports = reports;
    out_ready = 1'b0;
    expQ.push_back({1'b0, 5'd3});
    applyStimulus(7'b0110000, 10);
    vectors++;
    if (out_valid !== 1'b1 || out_index !== 5'd3 || out_overrun !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL overrun_hold3: valid=%0b index=%0d overrun=%0b, expected 1 3 0",
               out_valid, out_index, out_overrun);
    end
    applyStimulus(7'b0011001, 10);
    vectors++;
    if (out_valid !== 1'b1 || out_index !== 5'd3 || out_error !== 1'b0 || out_overrun !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL overrun_drop4: valid=%0b index=%0d error=%0b overrun=%0b, expected 1 3 0 1",
               out_valid, out_index, out_error, out_overrun);
    end
    out_ready = 1'b1;
    repeat (2) stepCycle();
    vectors++;
    if (out_valid !== 1'b0 || out_overrun !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL overrun_consume: valid=%0b overrun=%0b, expected 0 1", out_valid, out_overrun);
    end
    checkDrained("overrun_drain", startReports, 1);
    reset = 1'b1;
    repeat (2) stepCycle();
    reset = 1'b0;
    vectors++;
    if (out_overrun !== 1'b0 || out_valid !== 1'b0 || out_index !== 5'd19) begin
      miscompares++;
      $display("[TB] FAIL overrun_reset: overrun=%0b valid=%0b index=%0d, expected 0 0 19",
               out_overrun, out_valid, out_index);
    end
  endtask

  initial begin
    $display("[TB] seg_pattern_reader bench start");
    test_reset();
    test_latency();
    test_sweep();
    test_glitch();
    test_invalid();
    test_enable();
    test_overrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
